// File: rtl/sdf_fire_scheduler.sv
// Fire scheduler for an SDF actor shared by FLUX streams: round-robin arbitration,
// one-cycle FIFO read/fire strobe, then wait for the actor's completion pulse.
module sdf_fire_scheduler #(
  parameter int unsigned PORTS = 2,
  parameter int unsigned FLUX  = 2,
  parameter int unsigned CNT_W = 16
) (
  input  logic                  ck,
  input  logic                  rst,
  input  logic [PORTS*FLUX-1:0] in_empty,
  output logic [PORTS*FLUX-1:0] in_read,
  input  logic                  out_full,
  input  logic [FLUX-1:0]       en,
  input  logic                  done,
  output logic                  fire,
  output logic [FLUX-1:0]       fire_sel,
  output logic                  busy,
  output logic [CNT_W-1:0]      fire_cnt
);

  localparam int unsigned PTR_W = (FLUX > 1) ? $clog2(FLUX) : 1;

  typedef enum logic [1:0] {IDLE, READ, WAIT} state_t;

  state_t                  state;
  logic [PTR_W-1:0]        ptr;
  logic [PTR_W-1:0]        g;
  logic [PTR_W-1:0]        pick;
  logic [PTR_W-1:0]        idx;
  logic                    any;
  logic [FLUX-1:0]         eligible;
  logic [FLUX-1:0]         pick_oh;
  logic [PORTS*FLUX-1:0]   pick_mask;

  always_comb begin
    eligible = '0;
    for (int unsigned f = 0; f < FLUX; f++) begin
      eligible[f] = en[f] & ~|in_empty[f*PORTS +: PORTS] & ~out_full;
    end
  end

  // Scan upward from ptr with wrap-around; first eligible flux wins.
  always_comb begin
    any  = 1'b0;
    pick = '0;
    idx  = '0;
    for (int unsigned k = 0; k < FLUX; k++) begin
      idx = PTR_W'((32'(ptr) + k) % FLUX);
      if (!any && eligible[idx]) begin
        any  = 1'b1;
        pick = idx;
      end
    end
  end

  always_comb begin
    pick_oh   = '0;
    pick_mask = '0;
    for (int unsigned f = 0; f < FLUX; f++) begin
      pick_oh[f]                 = (pick == PTR_W'(f));
      pick_mask[f*PORTS +: PORTS] = {PORTS{pick_oh[f]}};
    end
  end

  always_ff @(posedge ck or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      ptr      <= '0;
      g        <= '0;
      fire_cnt <= '0;
      in_read  <= '0;
      fire     <= 1'b0;
      fire_sel <= '0;
      busy     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (any) begin
            g        <= pick;
            in_read  <= pick_mask;
            fire     <= 1'b1;
            fire_sel <= pick_oh;
            busy     <= 1'b1;
            state    <= READ;
          end
        end
        READ: begin
          in_read  <= '0;
          fire     <= 1'b0;
          fire_sel <= '0;
          state    <= WAIT;
        end
        WAIT: begin
          if (done) begin
            busy     <= 1'b0;
            ptr      <= (g == PTR_W'(FLUX - 1)) ? '0 : g + PTR_W'(1);
            fire_cnt <= fire_cnt + CNT_W'(1);
            state    <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sdf_fire_scheduler.sv
// Self-checking bench for sdf_fire_scheduler: expected grants queued at stimulus,
// popped and compared by a monitor whenever the DUT fires.
module tb_sdf_fire_scheduler;

  localparam int unsigned PORTS = 2;
  localparam int unsigned FLUX  = 2;
  localparam int unsigned CNT_W = 4;

  logic                  ck;
  logic                  rst;
  logic [PORTS*FLUX-1:0] in_empty;
  logic [PORTS*FLUX-1:0] in_read;
  logic                  out_full;
  logic [FLUX-1:0]       en;
  logic                  done;
  logic                  fire;
  logic [FLUX-1:0]       fire_sel;
  logic                  busy;
  logic [CNT_W-1:0]      fire_cnt;

  int         n_cmp = 0;
  int         n_err = 0;
  logic [1:0] exp_q[$];
  logic [1:0] mon_e;
  logic [3:0] exp_cnt;

  sdf_fire_scheduler #(.PORTS(PORTS), .FLUX(FLUX), .CNT_W(CNT_W)) dut (
    .ck       (ck),
    .rst      (rst),
    .in_empty (in_empty),
    .in_read  (in_read),
    .out_full (out_full),
    .en       (en),
    .done     (done),
    .fire     (fire),
    .fire_sel (fire_sel),
    .busy     (busy),
    .fire_cnt (fire_cnt)
  );

  initial begin
    ck = 1'b0;
    forever #5 ck = ~ck;
  end

  initial begin
    #50000;
    $display("FAIL watchdog: simulation exceeded time limit at %0t", $time);
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: observed 0x%0h, expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic step;
    @(posedge ck);
    #1;
  endtask

  task automatic do_reset;
    rst  = 1'b0;
    done = 1'b0;
    step;
    step;
    rst     = 1'b1;
    exp_cnt = '0;
  endtask

  // Waits for the grant, completes the firing with done in the first WAIT cycle.
  task automatic do_fire(input logic [1:0] sel, input int exp_wait);
    int waited = 0;
    exp_q.push_back(sel);
    while (fire !== 1'b1 && waited < 20) begin
      step;
      waited++;
    end
    check("grant_latency", waited, exp_wait);
    if (fire !== 1'b1) return;
    step;
    check("wait_fire", fire, 1'b0);
    check("wait_busy", busy, 1'b1);
    done = 1'b1;
    step;
    done = 1'b0;
    exp_cnt++;
    check("fire_cnt", fire_cnt, exp_cnt);
    check("idle_busy", busy, 1'b0);
  endtask

  always @(negedge ck) begin
    if (fire) begin
      if (exp_q.size() == 0) begin
        check("unexpected_fire", fire, 1'b0);
      end else begin
        mon_e = exp_q.pop_front();
        check("fire_sel", fire_sel, mon_e);
        check("in_read", in_read, {{2{mon_e[1]}}, {2{mon_e[0]}}});
        check("busy_read", busy, 1'b1);
      end
    end else if (in_read != '0) begin
      check("read_without_fire", in_read, 4'b0000);
    end
  end

  initial begin
    rst      = 1'b0;
    in_empty = '1;
    en       = '0;
    out_full = 1'b0;
    done     = 1'b0;
    exp_cnt  = '0;
    step;
    step;
    check("rst_in_read", in_read, 4'b0000);
    check("rst_fire", fire, 1'b0);
    check("rst_fire_sel", fire_sel, 2'b00);
    check("rst_busy", busy, 1'b0);
    check("rst_cnt", fire_cnt, 4'h0);

    // All FIFOs empty: stay idle
    en  = 2'b11;
    rst = 1'b1;
    repeat (5) begin
      step;
      check("empty_busy", busy, 1'b0);
      check("empty_fire", fire, 1'b0);
      check("empty_cnt", fire_cnt, 4'h0);
    end

    // Only flux 0 ready, then rotation picks flux 1 next
    in_empty = 4'b1100;
    do_fire(2'b01, 1);
    in_empty = '1;
    in_empty = 4'b0000;
    do_fire(2'b10, 1);
    in_empty = '1;

    // Continuous eligibility: alternating grants, one per 3 cycles
    do_reset;
    in_empty = 4'b0000;
    for (int i = 0; i < 6; i++) do_fire((i % 2 == 0) ? 2'b01 : 2'b10, 1);
    in_empty = '1;
    check("cnt_six", fire_cnt, 4'd6);
    step;
    check("six_idle_busy", busy, 1'b0);

    // out_full blocks; firing in progress survives out_full/en changes
    do_reset;
    in_empty = 4'b1100;
    out_full = 1'b1;
    repeat (4) begin
      step;
      check("blocked_fire", fire, 1'b0);
      check("blocked_busy", busy, 1'b0);
    end
    exp_q.push_back(2'b01);
    out_full = 1'b0;
    step;
    check("unblock_fire", fire, 1'b1);
    step;
    out_full = 1'b1;
    en       = 2'b00;
    in_empty = '1;
    step;
    check("hold_busy", busy, 1'b1);
    check("hold_fire", fire, 1'b0);
    done = 1'b1;
    step;
    done = 1'b0;
    exp_cnt++;
    check("full_done_cnt", fire_cnt, exp_cnt);
    check("full_done_busy", busy, 1'b0);
    step;
    step;
    check("full_no_fire", fire, 1'b0);

    // Reset mid-WAIT: async clear, later done ignored, scan restarts at flux 0
    out_full = 1'b0;
    en       = 2'b11;
    in_empty = 4'b0000;
    exp_q.push_back(2'b10);
    step;
    check("r_fire", fire, 1'b1);
    in_empty = '1;
    step;
    check("r_wait_busy", busy, 1'b1);
    #3 rst = 1'b0;
    #1;
    check("async_busy", busy, 1'b0);
    check("async_cnt", fire_cnt, 4'h0);
    check("async_in_read", in_read, 4'b0000);
    check("async_fire", fire, 1'b0);
    check("async_fire_sel", fire_sel, 2'b00);
    @(posedge ck);
    #1;
    rst     = 1'b1;
    exp_cnt = '0;
    done    = 1'b1;
    step;
    step;
    done = 1'b0;
    check("stale_done_cnt", fire_cnt, 4'h0);
    check("stale_done_busy", busy, 1'b0);
    in_empty = 4'b0000;
    do_fire(2'b01, 1);
    in_empty = '1;

    // 16 firings with a 4-bit counter wrap back to zero
    do_reset;
    in_empty = 4'b0000;
    for (int i = 0; i < 16; i++) do_fire((i % 2 == 0) ? 2'b01 : 2'b10, 1);
    in_empty = '1;
    check("wrap_cnt", fire_cnt, 4'h0);
    step;
    check("wrap_busy", busy, 1'b0);
    check("queue_drained", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
